oddeven_sorter: RTL and testbench
=================================

# oddeven_sorter

Parametrised odd-even transposition sorter: the successor to the bit-serial bubble sorter in the sort accelerator. It holds K_NUMBERS keys of N_BITS each and sorts them in place, one compare-exchange phase per clock. Runtime-selectable ascending/descending and signed/unsigned order, early termination, abort, and a sticky interrupt with acknowledge. It sits behind the same register-bank load/readback interface as its predecessor.

## Interface
- N_BITS, default 8: key width, ≥ 2
- K_NUMBERS, default 16: number of keys, ≥ 2
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  one clock; reset is asynchronous and active-low
- load_i  in  K_NUMBERS  per-element write enable; honoured only while idle
- writedata_i  in  K_NUMBERS*N_BITS  element i at bits [(i+1)*N_BITS-1 : i*N_BITS]
- readdata_o  out  K_NUMBERS*N_BITS  current element registers, same packing
- start_i  in  1  begin a sort; honoured only while idle
- descend_i  in  1  order select, sampled with start_i; 1 = element 0 holds the largest key
- signed_i  in  1  two's-complement compare, sampled with start_i
- abort_i  in  1  stop a running sort
- busy_o  out  1  sort in progress
- done_o  out  1  one-cycle pulse on normal completion
- aborted_o  out  1  one-cycle pulse on abort
- interrupt_o  out  1  sticky; set with done_o
- irq_ack_i  in  1  clears interrupt_o
- phases_o  out  $clog2(K_NUMBERS+1)  phases executed by the last or current sort

## Operation
- States: IDLE, SORT. Reset → IDLE. Reset values: all elements 0, busy_o 0, done_o 0, aborted_o 0, interrupt_o 0, phases_o 0, latched mode 0.
- IDLE: element i ← writedata_i slice on each edge with load_i[i]=1. On start_i: latch descend_i and signed_i, clear phases_o, clear swap flags, go to SORT. If load_i and start_i arrive together, the load is applied and the sort uses the loaded data.
- SORT, phase p (p = phases_o): even p compares pairs (0,1),(2,3)…; odd p compares pairs (1,2),(3,4)…. Out-of-order pairs are exchanged.
  - Ascending out-of-order: key[j] > key[j+1].
  - Descending out-of-order: key[j] < key[j+1].
  - Equal keys are never exchanged, so the sort is stable.
  - Signed mode compares as two's complement. Unsigned mode compares as unsigned.
- Per-phase swap flag = OR of all pair exchanges in that phase; phases_o increments by 1.
- Termination (checked at the end of each phase), goes to IDLE:
  - (a) an odd phase completes and neither it nor the immediately preceding even phase exchanged anything; or
  - (b) phases_o reaches K_NUMBERS.
- load_i and start_i are ignored in SORT.
- abort_i in SORT: no phase is executed on that edge; go to IDLE and pulse aborted_o. No done_o; interrupt_o is unchanged. Elements remain a permutation of the input. abort_i in IDLE is ignored. abort_i takes priority over a simultaneous termination.
- interrupt_o is set on the done edge and cleared by irq_ack_i. If set and ack occur on the same edge, set wins.
- Reset assertion mid-sort clears everything immediately; no done_o and no aborted_o.

## Timing
- start_i sampled at edge E0 → busy_o = 1 from E0.
- Phase p updates elements at edge E0+1+p; readdata_o reflects the result in the following cycle.
- Termination at edge Et:
  - busy_o falls at Et.
  - done_o = 1 for exactly the cycle after Et.
  - interrupt_o rises at Et.
- Minimum Et = E0+2 (already-sorted input). Maximum Et = E0+K_NUMBERS.
- A new start_i is accepted in the first cycle after Et.
- All outputs are registered. No combinational input→output path.

## Structure
- Shared package sort_pkg: sort-state enum (IDLE, SORT), order-mode constants, phase-counter width function.
- Sub-module cmp_exchange: combinational, one pair. Inputs a, b, descend, signed. Outputs lo_out, hi_out, swapped. Instantiated K_NUMBERS-1 times via generate; the parity of pair j selects which phase enables it.
- Top level contains the FSM, phase counter, swap-flag history, element registers and IRQ logic.

## Test plan
- K=4, N=8, load {3,1,4,2} (element 0 first), ascending unsigned, start → {1,2,3,4}; done_o one cycle after Et = E0+4; phases_o = 4; interrupt_o stays high until irq_ack_i.
- Preloaded {1,2,3,4}, start → no data change; Et = E0+2; phases_o = 2.
- Load {0x80,0x7F,0x00,0xFF}:
  - signed ascending → {0x80,0xFF,0x00,0x7F};
  - unsigned descending → {0xFF,0x80,0x7F,0x00}.
- K=16 reverse-ordered keys, abort_i at E0+3 → aborted_o pulse, no done_o, busy_o low from E0+3, phases_o = 2, data a permutation of the input; a following start completes normally.
- During SORT, pulse load_i and start_i → ignored, data unaffected. Same-edge load+start in IDLE → sort runs on the newly loaded data.
- rst_n asserted mid-sort → all elements, busy_o, interrupt_o and phases_o read 0 without waiting for a clock edge. Interrupt set and irq_ack_i on the same edge → interrupt_o stays 1.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and helpers for the odd-even transposition sorter.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package sort_pkg;

  // Top-level sorter state
  typedef enum logic {
    IDLE = 1'b0,
    SORT = 1'b1
  } sort_state_e;

  // Order select: descending puts the largest key in element 0
  localparam logic ORDER_ASC  = 1'b0;
  localparam logic ORDER_DESC = 1'b1;

  // Compare mode select
  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  // Phase counter must hold values 0..k inclusive
  function automatic int phase_w(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/oddeven_sorter_if.sv
// Register-bank load/readback and control bundle for the sorter.
// Latency: n/a (wires only).
// Backpressure: none; start/load are simply ignored while the sorter is busy.
interface oddeven_sorter_if
  import sort_pkg::*;
#(
  parameter int N_BITS    = 8,
  parameter int K_NUMBERS = 16
);
  localparam int PHASE_W = phase_w(K_NUMBERS);

  logic [K_NUMBERS-1:0]        load_i;
  logic [K_NUMBERS*N_BITS-1:0] writedata_i;
  logic [K_NUMBERS*N_BITS-1:0] readdata_o;
  logic                        start_i;
  logic                        descend_i;
  logic                        signed_i;
  logic                        abort_i;
  logic                        irq_ack_i;
  logic                        busy_o;
  logic                        done_o;
  logic                        aborted_o;
  logic                        interrupt_o;
  logic [PHASE_W-1:0]          phases_o;

  // Host side: drives loads and control, observes status
  modport master (
    output load_i, writedata_i, start_i, descend_i, signed_i, abort_i, irq_ack_i,
    input  readdata_o, busy_o, done_o, aborted_o, interrupt_o, phases_o
  );

  // Sorter side
  modport slave (
    input  load_i, writedata_i, start_i, descend_i, signed_i, abort_i, irq_ack_i,
    output readdata_o, busy_o, done_o, aborted_o, interrupt_o, phases_o
  );

endinterface

// File: rtl/cmp_exchange.sv
// One compare-exchange cell: orders a single adjacent key pair.
// Latency: combinational.
// Backpressure: n/a.
module cmp_exchange
  import sort_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic [N_BITS-1:0] a_i,        // key at the lower index
  input  logic [N_BITS-1:0] b_i,        // key at the higher index
  input  logic              descend_i,
  input  logic              signed_i,
  output logic [N_BITS-1:0] lo_out_o,   // result for the lower index
  output logic [N_BITS-1:0] hi_out_o,   // result for the higher index
  output logic              swapped_o
);

  logic a_gt_b;
  logic a_lt_b;

  // Decide whether the pair is out of order; equal keys never swap (stable)
  always_comb begin
    a_gt_b = 1'b0;
    a_lt_b = 1'b0;
    if (signed_i == MODE_SIGNED) begin
      a_gt_b = $signed(a_i) > $signed(b_i);
      a_lt_b = $signed(a_i) < $signed(b_i);
    end else begin
      a_gt_b = a_i > b_i;
      a_lt_b = a_i < b_i;
    end
    swapped_o = (descend_i == ORDER_DESC) ? a_lt_b : a_gt_b;
    lo_out_o  = swapped_o ? b_i : a_i;
    hi_out_o  = swapped_o ? a_i : b_i;
  end

endmodule

// File: rtl/oddeven_sorter.sv
// In-place odd-even transposition sorter, one compare-exchange phase per clock.
// Latency: done 2..K_NUMBERS edges after start, +1 cycle for the done pulse.
// Backpressure: load/start ignored while busy; abort ends the sort at once.
module oddeven_sorter
  import sort_pkg::*;
#(
  parameter int N_BITS    = 8,
  parameter int K_NUMBERS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  oddeven_sorter_if.slave  bus
);

  localparam int PHASE_W = phase_w(K_NUMBERS);
  localparam int NPAIR   = K_NUMBERS - 1;

  sort_state_e         state_q;
  logic [N_BITS-1:0]   key_q [K_NUMBERS];
  logic [N_BITS-1:0]   key_d [K_NUMBERS];
  logic [PHASE_W-1:0]  phase_q;
  logic                desc_q;
  logic                sgn_q;
  logic                prev_swap_q;   // swap flag of the previous phase
  logic                busy_q;
  logic                done_q;
  logic                aborted_q;
  logic                irq_q;

  logic [N_BITS-1:0]   lo_w [NPAIR];
  logic [N_BITS-1:0]   hi_w [NPAIR];
  logic [NPAIR-1:0]    swp_w;
  logic                phase_swap_d;
  logic                last_phase_d;
  logic                finish_d;

  // One cell per adjacent pair; the phase parity decides which cells take effect
  for (genvar j = 0; j < NPAIR; j++) begin : g_pair
    cmp_exchange #(.N_BITS(N_BITS)) u_cx (
      .a_i       (key_q[j]),
      .b_i       (key_q[j+1]),
      .descend_i (desc_q),
      .signed_i  (sgn_q),
      .lo_out_o  (lo_w[j]),
      .hi_out_o  (hi_w[j]),
      .swapped_o (swp_w[j])
    );
  end

  // Apply the enabled pairs of the current phase and decide on termination
  always_comb begin
    for (int i = 0; i < K_NUMBERS; i++) begin
      key_d[i] = key_q[i];
    end
    phase_swap_d = 1'b0;
    for (int j = 0; j < NPAIR; j++) begin
      if (j[0] == phase_q[0]) begin
        key_d[j]     = lo_w[j];
        key_d[j+1]   = hi_w[j];
        phase_swap_d = phase_swap_d | swp_w[j];
      end
    end
    // An odd phase plus its preceding even phase both clean means sorted
    last_phase_d = (32'(phase_q) + 1) == K_NUMBERS;
    finish_d     = (phase_q[0] && !phase_swap_d && !prev_swap_q) || last_phase_d;
  end

  // Control FSM, element registers, phase counter and interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < K_NUMBERS; i++) begin
        key_q[i] <= '0;
      end
      phase_q     <= '0;
      desc_q      <= ORDER_ASC;
      sgn_q       <= MODE_UNSIGNED;
      prev_swap_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      // Acknowledge first so a same-edge completion below wins
      if (bus.irq_ack_i) begin
        irq_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          for (int i = 0; i < K_NUMBERS; i++) begin
            if (bus.load_i[i]) begin
              key_q[i] <= bus.writedata_i[i*N_BITS +: N_BITS];
            end
          end
          if (bus.start_i) begin
            desc_q      <= bus.descend_i;
            sgn_q       <= bus.signed_i;
            phase_q     <= '0;
            prev_swap_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= SORT;
          end
        end
        SORT: begin
          if (bus.abort_i) begin
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            for (int i = 0; i < K_NUMBERS; i++) begin
              key_q[i] <= key_d[i];
            end
            phase_q     <= phase_q + 1'b1;
            prev_swap_q <= phase_swap_d;
            if (finish_d) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              irq_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Element readback uses the same packing as the write bus
  for (genvar g = 0; g < K_NUMBERS; g++) begin : g_rd
    assign bus.readdata_o[g*N_BITS +: N_BITS] = key_q[g];
  end

  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.aborted_o   = aborted_q;
  assign bus.interrupt_o = irq_q;
  assign bus.phases_o    = phase_q;

endmodule

// File: tb/tb_oddeven_sorter.sv
// Directed bench for oddeven_sorter with K=4 and K=16 instances.
// Latency: n/a.
// Backpressure: n/a.
module tb_oddeven_sorter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  typedef struct {
    logic [127:0] data;
    int           lat;
    int           phases;
  } exp_t;

  exp_t sb[$];

  oddeven_sorter_if #(.N_BITS(8), .K_NUMBERS(4))  if4 ();
  oddeven_sorter_if #(.N_BITS(8), .K_NUMBERS(16)) if16 ();

  oddeven_sorter #(.N_BITS(8), .K_NUMBERS(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  oddeven_sorter #(.N_BITS(8), .K_NUMBERS(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] e0, input logic [7:0] e1,
                                        input logic [7:0] e2, input logic [7:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic load4(input logic [31:0] d);
    if4.writedata_i = d;
    if4.load_i      = '1;
    tick();
    if4.load_i      = '0;
  endtask

  // Start a K=4 sort, wait for completion and compare against the scoreboard
  task automatic run4(input string tag, input logic [31:0] ld, input bit do_load,
                      input bit same_edge, input bit desc, input bit sgn,
                      input logic [31:0] exp_d, input int exp_lat, input int exp_ph,
                      input int ack_n, input bit disturb);
    exp_t e;
    int   n;
    sb.push_back('{data: {96'd0, exp_d}, lat: exp_lat, phases: exp_ph});
    if (do_load && !same_edge) load4(ld);
    if4.descend_i = desc;
    if4.signed_i  = sgn;
    if4.start_i   = 1'b1;
    if (same_edge) begin
      if4.writedata_i = ld;
      if4.load_i      = '1;
    end
    tick();
    if4.start_i = 1'b0;
    if4.load_i  = '0;
    chk({tag, ".busy_at_e0"}, {127'd0, if4.busy_o}, 128'd1);
    n = 0;
    while (1) begin
      if4.irq_ack_i = (n + 1 == ack_n);
      if (disturb && n == 1) begin
        if4.load_i      = '1;
        if4.writedata_i = '1;
        if4.start_i     = 1'b1;
      end
      tick();
      n++;
      if4.load_i    = '0;
      if4.start_i   = 1'b0;
      if4.irq_ack_i = 1'b0;
      if (!if4.busy_o) break;
      if (n >= 40) break;
    end
    e = sb.pop_front();
    chk({tag, ".latency"},   128'(n), 128'(e.lat));
    chk({tag, ".done"},      {127'd0, if4.done_o}, 128'd1);
    chk({tag, ".data"},      {96'd0, if4.readdata_o}, e.data);
    chk({tag, ".phases"},    {125'd0, if4.phases_o}, 128'(e.phases));
    chk({tag, ".interrupt"}, {127'd0, if4.interrupt_o}, 128'd1);
    tick();
    chk({tag, ".done_fall"}, {127'd0, if4.done_o}, 128'd0);
  endtask

  initial begin
    logic [127:0] wd;
    logic [127:0] exp16;
    logic [15:0]  seen;
    logic [7:0]   v;
    exp_t         e;
    int           n;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    if4.load_i  = '0; if4.writedata_i  = '0; if4.start_i  = 0; if4.descend_i  = 0;
    if4.signed_i  = 0; if4.abort_i  = 0; if4.irq_ack_i  = 0;
    if16.load_i = '0; if16.writedata_i = '0; if16.start_i = 0; if16.descend_i = 0;
    if16.signed_i = 0; if16.abort_i = 0; if16.irq_ack_i = 0;
    #12;
    chk("rst.data",    {96'd0, if4.readdata_o}, 128'd0);
    chk("rst.busy",    {127'd0, if4.busy_o}, 128'd0);
    chk("rst.done",    {127'd0, if4.done_o}, 128'd0);
    chk("rst.aborted", {127'd0, if4.aborted_o}, 128'd0);
    chk("rst.irq",     {127'd0, if4.interrupt_o}, 128'd0);
    chk("rst.phases",  {125'd0, if4.phases_o}, 128'd0);
    rst_n = 1'b1;
    tick();

    // Basic ascending unsigned sort, worst-case style latency
    run4("asc", pack4(3, 1, 4, 2), 1, 0, 0, 0, pack4(1, 2, 3, 4), 4, 4, 0, 0);
    tick(); tick(); tick();
    chk("irq.sticky", {127'd0, if4.interrupt_o}, 128'd1);
    if4.irq_ack_i = 1'b1;
    tick();
    if4.irq_ack_i = 1'b0;
    chk("irq.ack", {127'd0, if4.interrupt_o}, 128'd0);

    // Already sorted: early exit; ack collides with the done edge and loses
    run4("sorted", 32'd0, 0, 0, 0, 0, pack4(1, 2, 3, 4), 2, 2, 2, 0);

    // Signed ascending with load on the same edge as start
    run4("sgn_asc", pack4(8'h80, 8'h7F, 8'h00, 8'hFF), 1, 1, 0, 1,
         pack4(8'h80, 8'hFF, 8'h00, 8'h7F), 4, 4, 0, 0);

    // Unsigned descending
    run4("uns_desc", pack4(8'h80, 8'h7F, 8'h00, 8'hFF), 1, 0, 1, 0,
         pack4(8'hFF, 8'h80, 8'h7F, 8'h00), 4, 4, 0, 0);

    // Load and start pulsed mid-sort must be ignored
    run4("disturb", pack4(4, 3, 2, 1), 1, 0, 0, 0, pack4(1, 2, 3, 4), 4, 4, 0, 1);

    // K=16 reverse order, abort after two phases
    wd = '0;
    for (int i = 0; i < 16; i++) wd[i*8 +: 8] = 8'(15 - i);
    if16.writedata_i = wd;
    if16.load_i      = '1;
    tick();
    if16.load_i      = '0;
    if16.start_i     = 1'b1;
    tick();                        // E0
    if16.start_i     = 1'b0;
    tick();                        // E0+1
    tick();                        // E0+2
    if16.abort_i     = 1'b1;
    tick();                        // E0+3
    if16.abort_i     = 1'b0;
    chk("abort.busy",    {127'd0, if16.busy_o}, 128'd0);
    chk("abort.pulse",   {127'd0, if16.aborted_o}, 128'd1);
    chk("abort.done",    {127'd0, if16.done_o}, 128'd0);
    chk("abort.phases",  {123'd0, if16.phases_o}, 128'd2);
    chk("abort.irq",     {127'd0, if16.interrupt_o}, 128'd0);
    tick();
    chk("abort.pulse_fall", {127'd0, if16.aborted_o}, 128'd0);
    chk("abort.no_done",    {127'd0, if16.done_o}, 128'd0);
    seen = '0;
    for (int i = 0; i < 16; i++) begin
      v = if16.readdata_o[i*8 +: 8];
      if (v < 8'd16) seen[v[3:0]] = 1'b1;
    end
    chk("abort.perm", {112'd0, seen}, {112'd0, 16'hFFFF});

    // Restart after abort runs to completion
    exp16 = '0;
    for (int i = 0; i < 16; i++) exp16[i*8 +: 8] = 8'(i);
    sb.push_back('{data: exp16, lat: 0, phases: 0});
    if16.start_i = 1'b1;
    tick();
    if16.start_i = 1'b0;
    n = 0;
    while (if16.busy_o && n < 40) begin
      tick();
      n++;
    end
    e = sb.pop_front();
    chk("k16.finished", {127'd0, if16.busy_o}, 128'd0);
    chk("k16.done",     {127'd0, if16.done_o}, 128'd1);
    chk("k16.data",     if16.readdata_o, e.data);
    chk("k16.irq",      {127'd0, if16.interrupt_o}, 128'd1);

    // Asynchronous reset in the middle of a sort
    load4(pack4(4, 3, 2, 1));
    if4.start_i = 1'b1;
    tick();
    if4.start_i = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.data",    {96'd0, if4.readdata_o}, 128'd0);
    chk("arst.busy",    {127'd0, if4.busy_o}, 128'd0);
    chk("arst.irq",     {127'd0, if4.interrupt_o}, 128'd0);
    chk("arst.phases",  {125'd0, if4.phases_o}, 128'd0);
    chk("arst.irq16",   {127'd0, if16.interrupt_o}, 128'd0);
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    chk("arst.no_done",    {127'd0, if4.done_o}, 128'd0);
    chk("arst.no_aborted", {127'd0, if4.aborted_o}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
